// File: rtl/md_pkg.sv
// Shared types and op-decode helpers for the multiply/divide execute-stage sequencer.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_MULW = 3'd1,
    OP_DIV  = 3'd2,
    OP_DIVU = 3'd3,
    OP_REM  = 3'd4,
    OP_REMU = 3'd5,
    OP_DIVW = 3'd6,
    OP_REMW = 3'd7
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_RELEASE = 3'd2,
    ST_ABORT   = 3'd3,
    ST_RESP    = 3'd4
  } md_state_t;

  function automatic logic is_div(md_op_t op);
    return !(op == OP_MUL || op == OP_MULW);
  endfunction

  function automatic logic is_word(md_op_t op);
    return (op == OP_MULW || op == OP_DIVW || op == OP_REMW);
  endfunction

  function automatic logic div_signed(md_op_t op);
    return (op == OP_DIV || op == OP_REM || op == OP_DIVW || op == OP_REMW);
  endfunction

  function automatic logic div_rem(md_op_t op);
    return (op == OP_REM || op == OP_REMU || op == OP_REMW);
  endfunction

  // Quotient of x/0 is all-ones; remainder of x/0 is the dividend (word ops sign-extend it).
  function automatic logic [63:0] divzero_result(md_op_t op, logic [63:0] a);
    logic [63:0] res;
    res = '1;
    if (op == OP_REM || op == OP_REMU) res = a;
    else if (op == OP_REMW)            res = {{32{a[31]}}, a[31:0]};
    return res;
  endfunction

endpackage

// File: rtl/md_unit_port.sv
// Start/next handshake and result gating for one iterative arithmetic unit.
module md_unit_port
  #(parameter int XLEN = 64)
  (
    input  logic            rst_n,
    input  logic            sel,
    input  logic            run,
    input  logic            clear,
    input  logic            ok,
    input  logic [XLEN-1:0] result,
    output logic            start,
    output logic            next,
    output logic            done,
    output logic [XLEN-1:0] capt
  );

  // Reset holds next high so the unit is cleared however long reset lasts.
  assign start = rst_n & sel & run;
  assign next  = ~rst_n | (sel & clear);
  assign done  = start & ok;
  assign capt  = done ? result : '0;

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for the shared iterative multiplier and divider.
//
// state      | meaning
// IDLE       | waiting for a request
// RUN        | selected unit running, waiting for ok
// RELEASE    | one-cycle next pulse after completion
// ABORT      | one-cycle next pulse after a flush in RUN
// RESP       | result held until writeback takes it
module muldiv_ctrl
  import md_pkg::*;
  #(parameter int XLEN  = 64,
    parameter int TAG_W = 5)
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy,
    output logic             mul_start,
    output logic             mul_next,
    output logic             mul_word,
    output logic [XLEN-1:0]  mul_a,
    output logic [XLEN-1:0]  mul_b,
    input  logic [XLEN-1:0]  mul_result,
    input  logic             mul_ok,
    output logic             div_start,
    output logic             div_next,
    output logic             div_word,
    output logic             div_signed,
    output logic             div_rem,
    output logic [XLEN-1:0]  div_a,
    output logic [XLEN-1:0]  div_b,
    input  logic [XLEN-1:0]  div_result,
    input  logic             div_ok
  );

  md_state_t        state;
  md_op_t           op_q;
  logic [XLEN-1:0]  a_q, b_q, data_q;
  logic [TAG_W-1:0] tag_q;

  md_op_t           req_op_e;
  logic             accept, b_zero, run, clear;
  logic             mul_done, div_done;
  logic [XLEN-1:0]  mul_capt, div_capt;

  assign req_op_e = md_op_t'(req_op);
  assign accept   = req_valid & req_ready;
  assign b_zero   = is_word(req_op_e) ? (req_b[31:0] == 32'd0) : (req_b == '0);
  assign run      = (state == ST_RUN);
  assign clear    = (state == ST_RELEASE) || (state == ST_ABORT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_MUL;
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= req_op_e;
            a_q   <= req_a;
            b_q   <= req_b;
            tag_q <= req_tag;
            if (is_div(req_op_e) && b_zero) begin
              data_q <= XLEN'(divzero_result(req_op_e, 64'(req_a)));
              state  <= ST_RESP;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Flush wins over a same-cycle ok; the result is simply not captured.
          if (flush) begin
            state <= ST_ABORT;
          end else if (mul_done || div_done) begin
            data_q <= mul_capt | div_capt;
            state  <= ST_RELEASE;
          end
        end
        ST_RELEASE: state <= flush ? ST_IDLE : ST_RESP;
        ST_ABORT:   state <= ST_IDLE;
        ST_RESP:    if (flush || resp_ready) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  md_unit_port #(.XLEN(XLEN)) u_mul_port (
    .rst_n  (rst_n),
    .sel    (!is_div(op_q)),
    .run    (run),
    .clear  (clear),
    .ok     (mul_ok),
    .result (mul_result),
    .start  (mul_start),
    .next   (mul_next),
    .done   (mul_done),
    .capt   (mul_capt)
  );

  md_unit_port #(.XLEN(XLEN)) u_div_port (
    .rst_n  (rst_n),
    .sel    (is_div(op_q)),
    .run    (run),
    .clear  (clear),
    .ok     (div_ok),
    .result (div_result),
    .start  (div_start),
    .next   (div_next),
    .done   (div_done),
    .capt   (div_capt)
  );

  assign req_ready  = rst_n & (state == ST_IDLE) & ~flush;
  assign resp_valid = rst_n & (state == ST_RESP) & ~flush;
  assign busy       = rst_n & (state != ST_IDLE);
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;

  assign mul_word   = is_word(op_q) & ~is_div(op_q);
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign div_word   = is_word(op_q) & is_div(op_q);
  assign div_signed = is_div(op_q) & md_pkg::div_signed(op_q);
  assign div_rem    = is_div(op_q) & md_pkg::div_rem(op_q);
  assign div_a      = a_q;
  assign div_b      = b_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiplier/divider models.
module tb_muldiv_ctrl;
  import md_pkg::*;

  localparam int XLEN    = 64;
  localparam int TAG_W   = 5;
  localparam int MUL_LAT = 66;
  localparam int DIV_LAT = 20;

  logic             clk = 0;
  logic             rst_n, flush, req_valid, resp_ready;
  logic [2:0]       req_op;
  logic [XLEN-1:0]  req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready, resp_valid, busy;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             mul_start, mul_next, mul_word, mul_ok;
  logic [XLEN-1:0]  mul_a, mul_b, mul_result;
  logic             div_start, div_next, div_word, div_signed, div_rem, div_ok;
  logic [XLEN-1:0]  div_a, div_b, div_result;

  int checks = 0;
  int errors = 0;
  int mul_cnt = 0, div_cnt = 0;
  int mul_next_cnt = 0, div_next_cnt = 0, div_start_cnt = 0, resp_valid_cnt = 0, overlap_cnt = 0;
  int snap_a, snap_b, n;

  always #5 clk = ~clk;

  muldiv_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy),
    .mul_start(mul_start), .mul_next(mul_next), .mul_word(mul_word),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .mul_ok(mul_ok),
    .div_start(div_start), .div_next(div_next), .div_word(div_word),
    .div_signed(div_signed), .div_rem(div_rem),
    .div_a(div_a), .div_b(div_b), .div_result(div_result), .div_ok(div_ok)
  );

  function automatic logic [63:0] mul_model(logic [63:0] a, logic [63:0] b, logic w);
    logic [63:0] p;
    p = a * b;
    return w ? {{32{p[31]}}, p[31:0]} : p;
  endfunction

  function automatic logic [63:0] div_model(logic [63:0] a, logic [63:0] b,
                                            logic w, logic s, logic r);
    logic [63:0] q, rm, res;
    if (b == 64'd0) return '1;
    if (s) begin
      q  = $signed(a) / $signed(b);
      rm = $signed(a) % $signed(b);
    end else begin
      q  = a / b;
      rm = a % b;
    end
    res = r ? rm : q;
    return w ? {{32{res[31]}}, res[31:0]} : res;
  endfunction

  // Unit models: ok after LAT cycles of start, cleared by a next cycle.
  always @(posedge clk) begin
    if (mul_next) mul_cnt <= 0;
    else if (mul_start && mul_cnt < 1000) mul_cnt <= mul_cnt + 1;
    if (div_next) div_cnt <= 0;
    else if (div_start && div_cnt < 1000) div_cnt <= div_cnt + 1;
  end
  assign mul_ok     = mul_start && (mul_cnt >= MUL_LAT);
  assign div_ok     = div_start && (div_cnt >= DIV_LAT);
  assign mul_result = mul_model(mul_a, mul_b, mul_word);
  assign div_result = div_model(div_a, div_b, div_word, div_signed, div_rem);

  always @(posedge clk) begin
    if (mul_next)   mul_next_cnt   <= mul_next_cnt + 1;
    if (div_next)   div_next_cnt   <= div_next_cnt + 1;
    if (div_start)  div_start_cnt  <= div_start_cnt + 1;
    if (resp_valid) resp_valid_cnt <= resp_valid_cnt + 1;
    if ((mul_next && mul_start) || (div_next && div_start)) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the cycle after accept.
  task automatic issue(input md_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag);
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    #1 chk("issue_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
  endtask

  // Returns at the negedge where the selected unit's ok is high; cyc = cycles waited.
  task automatic wait_ok(input logic use_div, output int cyc);
    cyc = 0;
    while (!(use_div ? div_ok : mul_ok) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 300) chk("ok_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 0; flush = 0; req_valid = 0; resp_ready = 1;
    req_op = 3'd0; req_a = '0; req_b = '0; req_tag = '0;

    // Reset outputs
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_next", mul_next, 1);
    chk("rst_div_next", div_next, 1);
    chk("rst_resp_valid", resp_valid, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_mul_next", mul_next, 0);

    // MUL -3*7
    issue(OP_MUL, -64'sd3, 64'd7, 5'd3);
    snap_a = mul_next_cnt;
    chk("mul_start", mul_start, 1);
    chk("mul_div_start", div_start, 0);
    chk("mul_busy", busy, 1);
    chk("mul_req_ready", req_ready, 0);
    chk("mul_a", mul_a, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("mul_word0", mul_word, 0);
    wait_ok(0, n);
    chk("mul_latency", n, MUL_LAT);
    @(negedge clk);
    chk("mul_rel_start", mul_start, 0);
    chk("mul_rel_next", mul_next, 1);
    chk("mul_rel_resp_valid", resp_valid, 0);
    @(negedge clk);
    chk("mul_resp_valid", resp_valid, 1);
    chk("mul_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_resp_tag", resp_tag, 3);
    chk("mul_resp_next", mul_next, 0);
    @(negedge clk);
    chk("mul_after_valid", resp_valid, 0);
    chk("mul_after_ready", req_ready, 1);
    chk("mul_next_pulses", mul_next_cnt - snap_a, 1);

    // MULW
    issue(OP_MULW, 64'h0000_0001_8000_0000, 64'd2, 5'd4);
    chk("mulw_word", mul_word, 1);
    chk("mulw_b", mul_b, 2);
    wait_ok(0, n);
    chk("mulw_latency", n, MUL_LAT);
    repeat (2) @(negedge clk);
    chk("mulw_resp_valid", resp_valid, 1);
    chk("mulw_resp_data", resp_data, 64'h0);
    @(negedge clk);
    chk("mulw_after_ready", req_ready, 1);

    // Zero divisors, divider never started
    snap_a = div_start_cnt;
    issue(OP_REMW, 64'h0000_0001_8000_0005, 64'h0000_0001_0000_0000, 5'd5);
    chk("remw0_resp_valid", resp_valid, 1);
    chk("remw0_resp_data", resp_data, 64'hFFFF_FFFF_8000_0005);
    chk("remw0_resp_tag", resp_tag, 5);
    chk("remw0_div_start", div_start, 0);
    @(negedge clk);
    chk("remw0_after_ready", req_ready, 1);
    issue(OP_DIVU, 64'd5, 64'd0, 5'd6);
    chk("divu0_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    issue(OP_REMU, 64'd123, 64'd0, 5'd7);
    chk("remu0_resp_data", resp_data, 64'd123);
    @(negedge clk);
    chk("divzero_no_start", div_start_cnt - snap_a, 0);

    // DIVU with flush on the ok cycle
    snap_a = div_next_cnt;
    snap_b = resp_valid_cnt;
    issue(OP_DIVU, 64'd100, 64'd7, 5'd8);
    chk("divu_start", div_start, 1);
    chk("divu_mul_start", mul_start, 0);
    chk("divu_a", div_a, 100);
    chk("divu_signed", div_signed, 0);
    chk("divu_rem", div_rem, 0);
    chk("divu_word", div_word, 0);
    wait_ok(1, n);
    chk("divu_latency", n, DIV_LAT);
    flush = 1;
    #1 chk("flush_req_ready", req_ready, 0);
    @(negedge clk);
    flush = 0;
    chk("abort_div_start", div_start, 0);
    chk("abort_div_next", div_next, 1);
    chk("abort_busy", busy, 1);
    chk("abort_req_ready", req_ready, 0);
    @(negedge clk);
    chk("abort_after_ready", req_ready, 1);
    chk("abort_after_busy", busy, 0);
    chk("abort_after_next", div_next, 0);
    chk("abort_next_pulses", div_next_cnt - snap_a, 1);
    chk("abort_no_resp", resp_valid_cnt - snap_b, 0);

    // DIV -20/3 with writeback stalled
    resp_ready = 0;
    issue(OP_DIV, -64'sd20, 64'd3, 5'd9);
    chk("div_signed", div_signed, 1);
    wait_ok(1, n);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", resp_valid, 1);
      chk("stall_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFA);
      chk("stall_tag", resp_tag, 9);
      chk("stall_req_ready", req_ready, 0);
      @(negedge clk);
    end
    resp_ready = 1;
    req_valid = 1; req_op = OP_MUL; req_a = 64'd1; req_b = 64'd1; req_tag = 5'd1;
    #1 chk("hs_req_ready", req_ready, 0);
    @(negedge clk);
    chk("hs_no_accept_busy", busy, 0);
    chk("hs_resp_valid", resp_valid, 0);
    chk("hs_req_ready_after", req_ready, 1);
    req_valid = 0;
    @(negedge clk);

    // Reset mid-RUN
    issue(OP_MUL, 64'd5, 64'd6, 5'd10);
    repeat (5) @(negedge clk);
    chk("run_mul_start", mul_start, 1);
    rst_n = 0;
    #1;
    chk("midrst_mul_start", mul_start, 0);
    chk("midrst_mul_next", mul_next, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("postrst_busy", busy, 0);
    chk("postrst_req_ready", req_ready, 1);
    chk("postrst_mul_start", mul_start, 0);
    chk("postrst_mul_next", mul_next, 0);
    @(negedge clk);
    chk("next_start_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
